// File: rtl/cart_bus_arbiter_if.sv
// Cartridge bus arbitration signal bundle: core side, debug requester side and pad side.
// The slave modport is the arbiter's view; master is the surrounding logic's view.
interface cart_bus_arbiter_if;
  logic        core_halt;
  logic [15:0] core_a;
  logic [7:0]  core_dout;
  logic        core_rd;
  logic        core_wr;
  logic [7:0]  core_din;

  logic        dbg_req;
  logic        dbg_we;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata;
  logic        dbg_ack;
  logic [7:0]  dbg_rdata;
  logic        dbg_err;
  logic        dbg_owner;

  logic [15:0] bus_a;
  logic [7:0]  bus_dout;
  logic        bus_oe;
  logic        bus_rd;
  logic        bus_wr;
  logic [7:0]  bus_din;

  modport slave (
    input  core_halt, core_a, core_dout, core_rd, core_wr,
    output core_din,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata, dbg_err, dbg_owner,
    output bus_a, bus_dout, bus_oe, bus_rd, bus_wr,
    input  bus_din
  );

  modport master (
    output core_halt, core_a, core_dout, core_rd, core_wr,
    input  core_din,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata, dbg_err, dbg_owner,
    input  bus_a, bus_dout, bus_oe, bus_rd, bus_wr,
    output bus_din
  );
endinterface

// File: rtl/cart_bus_arbiter.sv
// Shares the cartridge bus between the core (combinational pass-through) and a debug requester
// (timed setup/strobe/hold cycle). Optional grant-wait timeout: define CART_ARB_TIMEOUT_EN.
module cart_bus_arbiter #(
  parameter int SETUP_CYC   = 2,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cart_bus_arbiter_if.slave    bus
);

  if (SETUP_CYC < 1 || SETUP_CYC > 255 || STROBE_CYC < 1 || STROBE_CYC > 255 ||
      HOLD_CYC < 1 || HOLD_CYC > 255 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_param
    $error("cart_bus_arbiter: timing parameter out of range");
  end

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        we_q;
  logic        owner_q;
  logic        rd_q;
  logic        wr_q;
  logic        ack_q;
  logic        err_q;
  logic [7:0]  rdata_q;
  logic        grant_ok;
  logic        timeout_hit;

  // Grant only when the core is frozen and not mid-access, so ownership never cuts a live strobe.
  assign grant_ok = bus.dbg_req & bus.core_halt & ~bus.core_rd & ~bus.core_wr;

`ifdef CART_ARB_TIMEOUT_EN
  logic [15:0] wait_cnt;

  assign timeout_hit = (state == IDLE) && bus.dbg_req && !grant_ok &&
                       (wait_cnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == IDLE && bus.dbg_req && !grant_ok && !timeout_hit) begin
      wait_cnt <= wait_cnt + 16'd1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_ok) begin
            state   <= SETUP;
            cnt     <= 8'(SETUP_CYC - 1);
            addr_q  <= bus.dbg_addr;
            we_q    <= bus.dbg_we;
            wdata_q <= bus.dbg_wdata;
            owner_q <= 1'b1;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            state <= DONE;
            ack_q <= 1'b1;
            err_q <= 1'b1;
          end
        end
        SETUP: begin
          if (!bus.core_halt) err_q <= 1'b1;
          if (cnt == 8'd0) begin
            state <= STROBE;
            cnt   <= 8'(STROBE_CYC - 1);
            rd_q  <= ~we_q;
            wr_q  <= we_q;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        STROBE: begin
          if (!bus.core_halt) err_q <= 1'b1;
          if (cnt == 8'd0) begin
            state <= HOLD;
            cnt   <= 8'(HOLD_CYC - 1);
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            if (!we_q) rdata_q <= bus.bus_din;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HOLD: begin
          if (!bus.core_halt) err_q <= 1'b1;
          if (cnt == 8'd0) begin
            state   <= DONE;
            owner_q <= 1'b0;
            ack_q   <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          // A request still held here is the tail of the finished handshake, not a new one.
          if (!bus.dbg_req) begin
            state <= IDLE;
            ack_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bus_a     = owner_q ? addr_q  : bus.core_a;
  assign bus.bus_dout  = owner_q ? wdata_q : bus.core_dout;
  assign bus.bus_oe    = owner_q ? we_q    : bus.core_wr;
  assign bus.bus_rd    = owner_q ? rd_q    : bus.core_rd;
  assign bus.bus_wr    = owner_q ? wr_q    : bus.core_wr;
  assign bus.core_din  = bus.bus_din;
  assign bus.dbg_owner = owner_q;
  assign bus.dbg_ack   = ack_q;
  assign bus.dbg_err   = err_q;
  assign bus.dbg_rdata = rdata_q;

endmodule

// File: doc/cart_bus_arbiter.md
# cart_bus_arbiter

Shares the cartridge bus (address, data, rd/wr strobes) between the `boy` core and a debug requester, such as the UART debug path, that needs to peek or poke cartridge memory. The core owns the bus by default through a combinational pass-through. A debug transaction is granted only while the core is halted and its bus is idle. The arbiter then runs a timed setup/strobe/hold cycle and returns ownership to the core. It sits between `boy` and the top-level `gb_a`/`gb_d`/`gb_rd`/`gb_wr` pad logic. Strobes are active-high here; the top level inverts them.

## Interface
- `SETUP_CYC`, default 2: cycles of address/data setup before the strobe; legal range 1..255.
- `STROBE_CYC`, default 4: cycles the rd/wr strobe is asserted; legal range 1..255.
- `HOLD_CYC`, default 1: cycles address/data are held after the strobe; legal range 1..255.
- `TIMEOUT_CYC`, default 65535: grant-wait limit in cycles; used only with `CART_ARB_TIMEOUT_EN`; 16-bit.

Ports:
- `clk`  in  1  single clock for all state.
- `rst_n`  in  1  asynchronous, active-low reset.
- `core_halt`  in  1  core is frozen; debug grant is permitted.
- `core_a`  in  16  core address.
- `core_dout`  in  8  core write data.
- `core_rd`, `core_wr`  in  1 each  core strobes.
- `core_din`  out  8  read data to core; always equals `bus_din`.
- `dbg_req`  in  1  debug request level.
- `dbg_we`  in  1  1 = write, 0 = read.
- `dbg_addr`  in  16  debug address.
- `dbg_wdata`  in  8  debug write data.
- `dbg_ack`  out  1  transaction complete; 4-phase handshake.
- `dbg_rdata`  out  8  captured read data.
- `dbg_err`  out  1  error flag; valid while `dbg_ack`=1.
- `bus_a`  out  16  cartridge address.
- `bus_dout`  out  8  cartridge write data.
- `bus_oe`  out  1  data pad output enable.
- `bus_rd`, `bus_wr`  out  1 each  cartridge strobes.
- `bus_din`  in  8  cartridge data pads.
- `dbg_owner`  out  1  1 while the debug requester owns the bus.

## Operation
- **States:** IDLE, SETUP, STROBE, HOLD, DONE. A single 8-bit counter times SETUP, STROBE and HOLD.
- **Bus muxing:**
  - `dbg_owner`=0: `bus_a`=`core_a`, `bus_dout`=`core_dout`, `bus_rd`=`core_rd`, `bus_wr`=`core_wr`, `bus_oe`=`core_wr`, all combinational.
  - `dbg_owner`=1: the bus is driven from registers. Core strobes are ignored during this time, and core accesses are lost.
- **IDLE → SETUP:** taken when `dbg_req` & `core_halt` & !`core_rd` & !`core_wr`. This transition latches `dbg_addr`/`dbg_we`/`dbg_wdata`, sets `dbg_owner`=1 and clears `dbg_err`.
- **SETUP:** `bus_a` = latched address. `bus_rd`=`bus_wr`=0. `bus_oe` = latched we, with `bus_dout` = latched wdata. Lasts `SETUP_CYC` cycles, then STROBE.
- **STROBE:** `bus_rd`=!we and `bus_wr`=we for `STROBE_CYC` cycles. On a read, `dbg_rdata` captures `bus_din` on the final STROBE cycle. Then HOLD.
- **HOLD:** strobes low; address, data and `bus_oe` unchanged for `HOLD_CYC` cycles. Then DONE.
- **DONE:** `dbg_owner`=0, so the core pass-through resumes on entry. `dbg_ack`=1 until `dbg_req`=0 is sampled, then IDLE. A request held high in DONE never starts a second transaction.
- **Halt lost:** if `core_halt`=0 is sampled in any of SETUP/STROBE/HOLD, the transaction still completes with unchanged timing, and `dbg_err`=1 at ack.
- **Request withdrawn:** `dbg_req` dropping during SETUP/STROBE/HOLD does not abort the transaction. Ack is then asserted for one cycle and the FSM returns to IDLE.
- **Reset mid-transaction:** any transaction in flight is abandoned immediately.
- **`dbg_rdata` on writes:** unchanged.

## Timing
- **Reset values:** state IDLE, `dbg_owner`=0, `dbg_ack`=0, `dbg_err`=0, `dbg_rdata`=8'h00, counter 0. Bus outputs follow the core pass-through immediately.
- **Latency:** `dbg_ack` rises 1+`SETUP_CYC`+`STROBE_CYC`+`HOLD_CYC` edges after the grant-qualifying edge; 8 edges with the defaults.
- **Grant wait:** unbounded while `core_halt`=0 or a core strobe is active (without the timeout feature).
- **Pass-through path:** purely combinational; zero latency.
- **Strobe glitches:** none at ownership changes. Ownership flips only in IDLE→SETUP (core strobes are low then) and HOLD→DONE (debug strobes are low then).

## Configuration
- `CART_ARB_TIMEOUT_EN` defined: a 16-bit counter runs while in IDLE with `dbg_req`=1 and the grant blocked.
  - When the count reaches `TIMEOUT_CYC`, the FSM goes directly to DONE with `dbg_err`=1, `dbg_rdata` unchanged and no bus activity.
  - The counter clears whenever `dbg_req`=0 or on grant.
- Undefined: no counter; a blocked request waits indefinitely.

## Test plan
- **Debug read:** `core_halt`=1, core idle, `bus_din`=8'h3C, read of 16'h0148 → `bus_a`=16'h0148. `bus_rd` high for exactly 4 cycles starting 3 edges after req. `dbg_ack` rises at edge 8, `dbg_rdata`=8'h3C, `dbg_err`=0.
- **Debug write:** write of 8'hA5 to 16'h2000 → `bus_oe`=1 and `bus_dout`=8'hA5 from SETUP through HOLD. `bus_wr` high 4 cycles; `bus_rd` stays 0. `dbg_rdata` unchanged.
- **Blocked grant:** `core_halt`=0 with `dbg_req`=1 → no grant; bus follows the core. Raise `core_halt` while `core_rd`=1 → still no grant. `core_rd`→0 → grant on the next edge.
- **Halt lost:** `core_halt` drops during STROBE → full timing is preserved, `dbg_err`=1 at ack, and `dbg_owner`=0 from DONE.
- **Reset mid-transaction:** `rst_n` low during STROBE → `bus_rd` follows `core_rd` immediately, `dbg_ack`=0, state IDLE.
- **Timeout (macro defined):** `TIMEOUT_CYC`=16, `core_halt`=0, `dbg_req` held → `dbg_ack`=1 with `dbg_err`=1 after 16 cycles, and no bus strobe occurs.
